mult_div_unit: RTL and testbench

//  E-stage multiply/divide unit with HI/LO registers. Consumes the decoder's start, md_op,

---
 rtl/mult_div_unit.sv | 66 ++++++
 tb/tb_mult_div_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit with HI/LO registers and a busy counter modelling mult/div latency.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hiWE,
    input  logic        loWE,
    input  logic        mdsel,
    output logic        busy,
    output logic [31:0] md_out
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    logic [31:0] hi, lo, op_a, op_b;
    logic [1:0]  op;
    logic [CW-1:0] cnt;
    logic        accept;
    logic [63:0] prod_s, prod_u, res;
    logic [31:0] mag_a, mag_b, mag_q, mag_r, uq, ur;
    assign busy   = cnt != '0;
    assign accept = start & ~req & ~busy & ~md_op[2];
    assign md_out = mdsel ? hi : lo;
    // Signed ops work on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
        prod_u = {32'b0, op_a} * {32'b0, op_b};
        mag_a  = op_a[31] ? -op_a : op_a;
        mag_b  = op_b[31] ? -op_b : op_b;
        mag_q  = mag_a / mag_b;
        mag_r  = mag_a % mag_b;
        uq     = op_a / op_b;
        ur     = op_a % op_b;
        res    = op == 2'b00 ? prod_s :
                 op == 2'b01 ? prod_u :
                 op == 2'b10 ? {(op_a[31] ? -mag_r : mag_r), ((op_a[31] ^ op_b[31]) ? -mag_q : mag_q)} :
                               {ur, uq};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            op_a <= '0;
            op_b <= '0;
            op   <= '0;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && !(op[1] && op_b == '0)) {hi, lo} <= res;
        end else if (accept) begin
            op_a <= A;
            op_b <= B;
            op   <= md_op[1:0];
            cnt  <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else begin
            if (hiWE && !req) hi <= A;
            if (loWE && !req) lo <= A;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against an arithmetic HI/LO model.
module tb_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;
    logic        clk = 0, reset = 1, req = 0, start = 0, hiWE = 0, loWE = 0, mdsel = 0;
    logic [2:0]  md_op = 0;
    logic [31:0] A = 0, B = 0;
    logic        busy;
    logic [31:0] md_out;
    logic [31:0] m_hi = 0, m_lo = 0;
    int n_cmp = 0, n_bad = 0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .md_op(md_op),
        .A(A), .B(B), .hiWE(hiWE), .loWE(loWE), .mdsel(mdsel),
        .busy(busy), .md_out(md_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_hilo(input string tag);
        mdsel = 1;
        #1 check({tag, "_hi"}, md_out, m_hi);
        mdsel = 0;
        #1 check({tag, "_lo"}, md_out, m_lo);
    endtask

    // Reference result from plain 64-bit arithmetic; divide by zero leaves HI/LO alone.
    task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x, y, p;
        longint unsigned pu;
        x = longint'($signed(a));
        y = longint'($signed(b));
        case (op)
            2'd0: begin p = x * y; {m_hi, m_lo} = p; end
            2'd1: begin pu = longint'({32'b0, a}) * longint'({32'b0, b}); {m_hi, m_lo} = pu; end
            2'd2: if (b != 0) begin m_lo = 32'(x / y); m_hi = 32'(x % y); end
            default: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
        endcase
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb);
        int n;
        n = op[1] ? DC : MC;
        start = 1; md_op = {1'b0, op}; A = a; B = b;
        tick();
        start = 0; A = $urandom; B = $urandom;
        for (int i = 0; i < n; i++) begin
            if (disturb && i == 1) begin
                start = 1; md_op = 3'($urandom_range(0, 3)); hiWE = 1; loWE = 1;
            end
            if (disturb && i == 2) begin
                start = 0; hiWE = 0; loWE = 0; req = 1;
            end
            if (disturb && i == 3) req = 0;
            check({tag, "_busy"}, 32'(busy), 32'd1);
            tick();
        end
        req = 0; start = 0; hiWE = 0; loWE = 0;
        check({tag, "_done"}, 32'(busy), 32'd0);
        model_op(op, a, b);
        chk_hilo(tag);
    endtask

    task automatic move_to(input string tag, input bit wh, input bit wl, input logic [31:0] a, input bit r);
        hiWE = wh; loWE = wl; A = a; req = r;
        tick();
        hiWE = 0; loWE = 0; req = 0; A = $urandom;
        if (!r && wh) m_hi = a;
        if (!r && wl) m_lo = a;
        chk_hilo(tag);
    endtask

    initial begin
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        chk_hilo("reset");
        reset = 0;
        tick();
        run_op("t1_mult", 2'd0, 32'hFFFFFFFD, 32'd5, 0);
        check("t1_hi_const", m_hi, 32'hFFFFFFFF);
        run_op("t2_multu", 2'd1, 32'hFFFFFFFF, 32'd2, 1);
        run_op("t3_div", 2'd2, 32'hFFFFFFF9, 32'd2, 0);
        run_op("t3_divu", 2'd3, 32'hFFFFFFF9, 32'd2, 0);
        move_to("t4_mthi", 1, 0, 32'h12345678, 0);
        run_op("t4_divu0", 2'd3, 32'hDEADBEEF, 32'd0, 0);
        run_op("t4_div0", 2'd2, 32'h00000123, 32'd0, 0);
        run_op("ovf_div", 2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        // Flushed start and flushed mtlo must not take effect.
        start = 1; md_op = 3'd0; req = 1; A = 32'd7; B = 32'd9;
        tick();
        start = 0; req = 0;
        check("t5_req_busy", 32'(busy), 32'd0);
        chk_hilo("t5_req_start");
        move_to("t5_req_mtlo", 0, 1, 32'hCAFEF00D, 1);
        move_to("both_we", 1, 1, 32'hA5A5A5A5, 0);
        start = 1; md_op = 3'd5;
        tick();
        start = 0;
        check("bad_op_busy", 32'(busy), 32'd0);
        // Coincident start and write enable: the operation wins.
        hiWE = 1; loWE = 1;
        run_op("start_wins", 2'd1, 32'd3, 32'd4, 0);
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20)) : $urandom);
            if ($urandom_range(0, 4) == 0)
                move_to("rnd_mt", 1'($urandom), 1'($urandom), a, 1'($urandom));
            else
                run_op("rnd_op", 2'($urandom_range(0, 3)), a, b, 1'($urandom));
        end
        move_to("t6_pre", 1, 1, 32'h55AA55AA, 0);
        start = 1; md_op = 3'd3; A = 32'd100; B = 32'd7;
        tick();
        start = 0;
        tick(); tick();
        #2 reset = 1;
        #1 check("t6_busy", 32'(busy), 32'd0);
        m_hi = 0; m_lo = 0;
        chk_hilo("t6_async");
        tick();
        reset = 0;
        for (int i = 0; i < DC + 2; i++) tick();
        check("t6_late_busy", 32'(busy), 32'd0);
        chk_hilo("t6_late");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
